// File: rtl/fcl_fp_stream.sv
// Fixed-point fully-connected layer engine: PARALLEL neurons accumulate a broadcast
// activation stream, then round, shift, ReLU and saturate into a 1-deep output slot.
module fcl_fp_stream #(
  parameter int FP_WIDTH  = 8,
  parameter int ACC_WIDTH = 32,
  parameter int PARALLEL  = 8,
  parameter int SH_W      = $clog2(ACC_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic [FP_WIDTH-1:0]          in_data,
  input  logic [PARALLEL*FP_WIDTH-1:0] in_w,
  input  logic [PARALLEL*FP_WIDTH-1:0] bias,
  input  logic [SH_W-1:0]              cfg_shift,
  input  logic                         cfg_relu,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PARALLEL*FP_WIDTH-1:0] out_data,
  output logic [PARALLEL-1:0]          ovf
);

  localparam int PW = 2 * FP_WIDTH;
  localparam int RW = ACC_WIDTH + 1;
  localparam logic signed [RW-1:0] MAXV = RW'((2 ** (FP_WIDTH - 1)) - 1);
  localparam logic signed [RW-1:0] MINV = RW'(-(2 ** (FP_WIDTH - 1)));

  // Handshake: a beat moves on in_valid & in_ready; a result moves on out_valid & out_ready.
  // The output slot is 1 deep, so every beat stalls while a result is held unaccepted.
  logic                        first;
  logic                        accept;
  logic signed [ACC_WIDTH-1:0] acc   [PARALLEL];
  logic signed [ACC_WIDTH-1:0] sum_d [PARALLEL];
  logic [PARALLEL-1:0]         ovf_now;
  logic [PARALLEL*FP_WIDTH-1:0] res_d;
  logic signed [RW-1:0]        half;

  assign in_ready = ~rst & (~out_valid | out_ready);
  assign accept   = in_valid & in_ready;

  // Rounding offset is half an output LSB; zero when no shift is applied.
  assign half = (cfg_shift == '0) ? '0 : (RW'(1) << (cfg_shift - SH_W'(1)));

  genvar g;
  for (g = 0; g < PARALLEL; g++) begin : g_lane
    logic signed [FP_WIDTH-1:0]  w;
    logic signed [FP_WIDTH-1:0]  b;
    logic signed [PW-1:0]        prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] base;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [RW-1:0]        t_ext;
    logic signed [RW-1:0]        rnd;
    logic signed [RW-1:0]        r;
    logic [FP_WIDTH-1:0]         res;

    assign w        = in_w[g*FP_WIDTH +: FP_WIDTH];
    assign b        = bias[g*FP_WIDTH +: FP_WIDTH];
    assign prod     = $signed(in_data) * w;
    assign prod_ext = ACC_WIDTH'(prod);
    assign base     = first ? ACC_WIDTH'(b) : acc[g];
    assign sum      = base + prod_ext;
    assign ovf_now[g] = (base[ACC_WIDTH-1] == prod_ext[ACC_WIDTH-1]) &&
                        (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
    assign sum_d[g] = sum;

    // One extra bit keeps t + half from wrapping before the shift.
    assign t_ext = RW'(sum);
    assign rnd   = t_ext + half;
    assign r     = rnd >>> cfg_shift;

    always_comb begin
      res = r[FP_WIDTH-1:0];
      if (cfg_relu && (r < 0)) begin
        res = '0;
      end else if (r > MAXV) begin
        res = MAXV[FP_WIDTH-1:0];
      end else if (r < MINV) begin
        res = MINV[FP_WIDTH-1:0];
      end
    end

    assign res_d[g*FP_WIDTH +: FP_WIDTH] = res;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      first     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      ovf       <= '0;
      for (int i = 0; i < PARALLEL; i++) begin
        acc[i] <= '0;
      end
    end else begin
      if (accept) begin
        first <= in_last;
        ovf   <= ovf | ovf_now;
        for (int i = 0; i < PARALLEL; i++) begin
          acc[i] <= sum_d[i];
        end
      end
      // A new result may replace the one draining this cycle, keeping full throughput.
      if (accept && in_last) begin
        out_valid <= 1'b1;
        out_data  <= res_d;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fcl_fp_stream.sv
// Directed bench for fcl_fp_stream: driver tasks issue beats and queue expected
// results; a negedge monitor pops and compares on each output handshake.
module tb_fcl_fp_stream;

  localparam int FW  = 8;
  localparam int PAR = 8;
  localparam int AW  = 32;
  localparam int SHW = 5;
  localparam int DW  = PAR * FW;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic          in_last;
  logic [FW-1:0] in_data;
  logic [DW-1:0] in_w;
  logic [DW-1:0] bias;
  logic [SHW-1:0] cfg_shift;
  logic          cfg_relu;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [PAR-1:0] ovf;

  logic          in_ready16;
  logic          out_valid16;
  logic [DW-1:0] out_data16;
  logic [PAR-1:0] ovf16;

  logic [DW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_pop_cyc = -10;
  int run_len = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fcl_fp_stream #(.FP_WIDTH(FW), .ACC_WIDTH(AW), .PARALLEL(PAR)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_data(in_data), .in_w(in_w), .bias(bias), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .ovf(ovf)
  );

  // Narrow-accumulator copy, fed the same stream, to exercise overflow.
  fcl_fp_stream #(.FP_WIDTH(FW), .ACC_WIDTH(16), .PARALLEL(PAR)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16), .in_last(in_last),
    .in_data(in_data), .in_w(in_w), .bias(bias), .cfg_shift(cfg_shift[3:0]), .cfg_relu(cfg_relu),
    .out_valid(out_valid16), .out_ready(out_ready), .out_data(out_data16), .ovf(ovf16)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rep(input int v);
    logic [DW-1:0] r;
    for (int i = 0; i < PAR; i++) r[i*FW +: FW] = v[FW-1:0];
    return r;
  endfunction

  function automatic logic [DW-1:0] lanes8(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
    return {a7[7:0], a6[7:0], a5[7:0], a4[7:0], a3[7:0], a2[7:0], a1[7:0], a0[7:0]};
  endfunction

  // ---------------- driver ----------------
  task automatic send_beat(input int d, input bit last);
    bit ok;
    int n;
    in_valid = 1'b1;
    in_data  = d[FW-1:0];
    in_last  = last;
    n = 0;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL beat_accept: got no accept expected accept within 200 cycles");
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d results outstanding expected 0", name, exp_q.size());
      exp_q.delete();
    end
    #1;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got %h expected none", out_data);
      end else begin
        check("result", out_data, exp_q.pop_front());
      end
      run_len = (cyc == last_pop_cyc + 1) ? run_len + 1 : 1;
      last_pop_cyc = cyc;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_w = '0; bias = '0;
    cfg_shift = '0; cfg_relu = 1'b0; out_ready = 1'b1;

    // Reset values
    @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", DW'(out_valid), DW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_ovf", DW'(ovf), DW'(0));
    check("rst_in_ready", DW'(in_ready), DW'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", DW'(in_ready), DW'(1));
    @(posedge clk); #1;

    // 4-beat vector, 1+2+3+4 times 3; bias/shift junk off their sampling beats
    bias = '0; in_w = rep(3); cfg_shift = 5'd3; cfg_relu = 1'b0;
    exp_q.push_back(rep(30));
    send_beat(1, 0);
    bias = rep(99);
    send_beat(2, 0);
    send_beat(3, 0);
    cfg_shift = '0;
    send_beat(4, 1);
    @(negedge clk);
    check("latency_out_valid", DW'(out_valid), DW'(1));
    drain("vec4");

    // Rounding with shift 2 plus ReLU
    bias = '0; in_w = lanes8(1, -10, 100, -100, 7, -1, 0, 3); cfg_shift = 5'd2; cfg_relu = 1'b1;
    exp_q.push_back(lanes8(3, 0, 127, 0, 18, 0, 0, 8));
    send_beat(10, 1);
    drain("round_relu");

    // Saturation without shift or ReLU
    cfg_shift = '0; cfg_relu = 1'b0;
    exp_q.push_back(lanes8(10, -100, 127, -128, 70, -10, 0, 30));
    send_beat(10, 1);
    drain("saturate");

    // Half-up rounding on negatives and positives, shift 1
    bias = lanes8(0, 0, 0, 0, 0, 0, 0, 8); in_w = lanes8(1, -1, 0, -5, 5, 2, -2, 1);
    cfg_shift = 5'd1;
    exp_q.push_back(lanes8(-1, 2, 0, 8, -7, -3, 3, 3));
    send_beat(-3, 1);
    drain("round_half");

    // Backpressure: result held, next vector stalls then completes intact
    out_ready = 1'b0; cfg_shift = '0; bias = '0; in_w = rep(5);
    exp_q.push_back(rep(10));
    send_beat(2, 1);
    fork
      begin
        bias = rep(1); in_w = rep(2);
        exp_q.push_back(rep(9));
        for (int k = 0; k < 4; k++) send_beat(1, k == 3);
      end
      begin
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          check("stall_in_ready", DW'(in_ready), DW'(0));
          check("stall_hold_data", out_data, rep(10));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("backpressure");

    // Back-to-back single-beat vectors at full throughput
    bias = rep(5); in_w = rep(-1);
    for (int k = 0; k < 4; k++) exp_q.push_back(rep(3));
    for (int k = 0; k < 4; k++) send_beat(2, 1);
    drain("b2b");
    check("b2b_consecutive", DW'(run_len), DW'(4));

    // Reset mid-vector discards the partial sum
    bias = '0; in_w = rep(7);
    send_beat(7, 0);
    send_beat(7, 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", DW'(out_valid), DW'(0));
    @(posedge clk); #1;
    bias = '0; in_w = rep(1);
    exp_q.push_back(rep(1));
    send_beat(1, 1);
    drain("mid_reset");

    // Overflow: 16-bit accumulator wraps on the third 127*127 beat, 32-bit does not
    check("ovf16_clear", DW'(ovf16), DW'(0));
    in_w = rep(127); bias = '0;
    exp_q.push_back(rep(127));
    for (int k = 0; k < 4; k++) send_beat(127, k == 3);
    drain("ovf_vec");
    check("ovf16_set", DW'(ovf16), DW'(8'hFF));
    check("ovf32_clear", DW'(ovf), DW'(0));
    in_w = rep(1);
    exp_q.push_back(rep(1));
    send_beat(1, 1);
    drain("ovf_after");
    check("ovf16_sticky", DW'(ovf16), DW'(8'hFF));
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("ovf16_rst", DW'(ovf16), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fcl_fp_stream.md
Name: fcl_fp_stream

Overview:
- Next-generation fixed-point fully-connected layer engine.
- Computes PARALLEL output neurons per pass over a streamed input vector.
- Per beat: one broadcast activation plus PARALLEL weights; each lane accumulates a per-lane bias plus the products.
- On the last beat, each lane rounds, shifts, optionally applies ReLU and saturates, then presents the result on a valid/ready output port. Sits between the activation buffer and the next layer's input FIFO.

Parameters:
- FP_WIDTH, 8, signed width of activations, weights, biases and outputs
- ACC_WIDTH, 32, signed accumulator width per lane; must be ≥ 2*FP_WIDTH+1
- PARALLEL, 8, number of output lanes (neurons per pass)
- SH_W, $clog2(ACC_WIDTH), width of shift control

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  input beat accepted when in_valid & in_ready
- in_last  in  1  marks final beat of a vector
- in_data  in  FP_WIDTH  signed activation, broadcast to all lanes
- in_w  in  PARALLEL*FP_WIDTH  signed weights, lane i = bits [i*FP_WIDTH +: FP_WIDTH]
- bias  in  PARALLEL*FP_WIDTH  signed per-lane bias, sampled on first beat of a vector
- cfg_shift  in  SH_W  arithmetic right shift applied at output, sampled on last beat
- cfg_relu  in  1  1 = clamp negatives to 0, sampled on last beat
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts when out_valid & out_ready
- out_data  out  PARALLEL*FP_WIDTH  signed results, same lane packing as in_w
- ovf  out  PARALLEL  sticky per-lane accumulator overflow flag

Behaviour:
- Reset (rst=1 at an edge):
  - out_valid=0, out_data=0, ovf=0.
  - All accumulators=0; first-beat flag=1.
  - Takes effect mid-vector: the partial sum is discarded and the next accepted beat starts a new vector.
- Handshake:
  - in_ready = ~out_valid | out_ready, combinational. The output is a 1-deep slot, so a beat is stalled only when the slot is full and not draining.
  - in_ready applies to every beat, not just last beats.
  - in_ready is low during the reset cycle.
- Accumulate on an accepted beat, prod_i = in_data*in_w[i] (full 2*FP_WIDTH signed, sign-extended to ACC_WIDTH):
  - first-beat flag=1: acc_i <= sext(bias_i) + prod_i
  - otherwise: acc_i <= acc_i + prod_i
  - in_last accepted: first-beat flag <= 1; otherwise first-beat flag <= 0.
  - A single-beat vector (first and last together) is legal: result = bias + prod.
- Overflow:
  - Accumulator add wraps two's complement.
  - ovf[i] is set when signed overflow occurs (operands same sign, result differs) and stays set until rst.
- Output computation, on the accepted last beat, per lane with s=cfg_shift and t = final acc value including this beat's product:
  - r = (s==0) ? t : (t + (1<<(s-1))) >>> s (round half up, ACC_WIDTH+1 bit intermediate, no wrap)
  - if cfg_relu and r<0: r=0
  - saturate r to [-2^(FP_WIDTH-1), 2^(FP_WIDTH-1)-1]
- Output register:
  - out_data and out_valid=1 are registered in the cycle after the last beat is accepted (latency 1).
  - Held stable while out_valid & ~out_ready.
  - out_valid clears after an out handshake unless a new last beat is accepted the same cycle. In that case out_valid stays 1 and out_data is replaced (back-to-back results, full throughput).
- Non-last beats may be accepted while out_valid=1 and out_ready=0? No. in_ready=0 stalls all beats; partial vector state is preserved while stalled.
- Inputs are ignored when in_valid=0. bias, cfg_shift and cfg_relu are don't-care outside their sampling beat.

Test Plan:
- Reset check: rst=1 for 2 cycles -> out_valid=0, out_data=0, ovf=0, in_ready=0 during reset, 1 after.
- 4-beat vector, PARALLEL=8, FP_WIDTH=8, bias=0, data {1,2,3,4}, all weights 3, shift=0, relu=0, out_ready=1 -> one cycle after last beat: out_valid=1, all lanes 30.
- Rounding, saturation and ReLU:
  - lane 0 acc=10, shift=2 -> 3 (10+2=12>>>2)
  - lane 1 acc=-100, relu=1 -> 0
  - lane 2 acc=1000, shift=0 -> 127
  - lane 3 acc=-1000, relu=0 -> -128
- Backpressure: out_ready=0 after result 1 -> in_ready=0, next vector's beats stall. out_data holds across 5 stall cycles. Release -> second vector completes with correct sum and no lost beat.
- Back-to-back single-beat vectors, bias=5, data=2, w=-1, out_ready=1 continuously -> out_valid high every cycle after the first, each lane 3.
- Reset mid-vector after 2 of 4 beats, then a fresh 1-beat vector data=1, w=1, bias=0 -> result 1. For overflow: ACC_WIDTH=16, repeated 127*127 beats -> ovf set and held until rst.
